uart_transceiver: RTL and testbench

Full-duplex 8N1 UART: one transmitter path (parallel byte to serial TxD) and one receiver path (serial RxD to parallel byte plus valid strobe), sharing a single clock and reset. Sits between a byte-oriented host interface and the board UART pins. Default timing: 50 MHz clock, 115200 baud.

---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_tx_engine.sv | 97 +++++++++
 rtl/uart_transceiver.sv | 131 +++++++++++++
 tb/tb_uart_transceiver.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the 8N1 UART transceiver.
package uart_pkg;

  localparam int unsigned DATA_BITS = 8;

  typedef enum logic [1:0] {TxIdle, TxStart, TxBits, TxStop} tx_state_t;

  typedef enum logic [2:0] {RxIdle, RxStart, RxBits, RxStop, RxWaitIdle} rx_state_t;

  function automatic int unsigned clks_per_bit(input int unsigned clk_freq,
                                               input int unsigned baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_tx_engine.sv
// UART transmit path: FSM, shift register and bit counter; TxD and busy are registered.
module uart_tx_engine
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 transmit_i,
  input  logic [DATA_BITS-1:0] tx_data_i,
  output logic                 txd_o,
  output logic                 busy_o
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] CntLast = CntW'(CLKS_PER_BIT - 1);

  tx_state_t            state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [2:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 txd_q, txd_d;
  logic                 busy_q, busy_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= TxIdle;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      txd_q   <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      txd_q   <= txd_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CntW'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    unique case (state_q)
      TxIdle: begin
        cnt_d = '0;
        if (transmit_i) begin
          state_d = TxStart;
          shift_d = tx_data_i;
          bit_d   = '0;
        end
      end
      TxStart: begin
        if (cnt_q == CntLast) begin
          cnt_d   = '0;
          state_d = TxBits;
        end
      end
      TxBits: begin
        if (cnt_q == CntLast) begin
          cnt_d = '0;
          if (bit_q == 3'(DATA_BITS - 1)) begin
            state_d = TxStop;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[DATA_BITS-1:1]};
          end
        end
      end
      TxStop: begin
        if (cnt_q == CntLast) begin
          cnt_d   = '0;
          state_d = TxIdle;
        end
      end
      default: state_d = TxIdle;
    endcase
  end

  // Outputs are decoded from the next state so they update on the same edge as the FSM.
  always_comb begin
    busy_d = (state_d != TxIdle);
    unique case (state_d)
      TxStart: txd_d = 1'b0;
      TxBits:  txd_d = shift_d[0];
      default: txd_d = 1'b1;
    endcase
  end

  assign txd_o  = txd_q;
  assign busy_o = busy_q;

endmodule

// File: rtl/uart_transceiver.sv
// Full-duplex 8N1 UART: TX engine plus synchronised RX path.
// Define UART_LOOPBACK_EN to feed the receiver from TxD instead of the RxD pin.
module uart_transceiver
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ     = 50000000,
  parameter int unsigned BAUD         = 115200,
  parameter int unsigned CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 transmit,
  input  logic [DATA_BITS-1:0] TxData,
  output logic                 TxD,
  output logic                 busy,
  input  logic                 RxD,
  output logic [DATA_BITS-1:0] RxData,
  output logic                 valid_rx
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] CntLast = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0] CntHalf = CntW'(CLKS_PER_BIT / 2 - 1);

  uart_tx_engine #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .clk       (clk),
    .reset     (reset),
    .transmit_i(transmit),
    .tx_data_i (TxData),
    .txd_o     (TxD),
    .busy_o    (busy)
  );

  logic rx_in;
`ifdef UART_LOOPBACK_EN
  logic unused_rxd;
  assign unused_rxd = RxD;
  assign rx_in      = TxD;
`else
  assign rx_in = RxD;
`endif

  // Synchroniser flops reset to the idle line level so reset never looks like a start edge.
  logic rx_meta_q, rx_sync_q, rx_prev_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= rx_in;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  rx_state_t            rx_state_q, rx_state_d;
  logic [CntW-1:0]      rx_cnt_q, rx_cnt_d;
  logic [2:0]           rx_bit_q, rx_bit_d;
  logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_state_q <= RxIdle;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
    end
  end

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q + CntW'(1);
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    unique case (rx_state_q)
      RxIdle: begin
        rx_cnt_d = '0;
        if (rx_prev_q && !rx_sync_q) rx_state_d = RxStart;
      end
      RxStart: begin
        if (rx_cnt_q == CntHalf) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_state_d = rx_sync_q ? RxIdle : RxBits;
        end
      end
      RxBits: begin
        if (rx_cnt_q == CntLast) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_sync_q, rx_shift_q[DATA_BITS-1:1]};
          if (rx_bit_q == 3'(DATA_BITS - 1)) rx_state_d = RxStop;
          else rx_bit_d = rx_bit_q + 3'd1;
        end
      end
      RxStop: begin
        if (rx_cnt_q == CntLast) begin
          rx_cnt_d   = '0;
          rx_state_d = rx_sync_q ? RxIdle : RxWaitIdle;
        end
      end
      RxWaitIdle: begin
        rx_cnt_d = '0;
        if (rx_sync_q) rx_state_d = RxIdle;
      end
      default: rx_state_d = RxIdle;
    endcase
  end

  always_comb begin
    rx_valid_d = (rx_state_q == RxStop) && (rx_cnt_q == CntLast) && rx_sync_q;
    rx_data_d  = rx_valid_d ? rx_shift_q : rx_data_q;
  end

  assign RxData   = rx_data_q;
  assign valid_rx = rx_valid_q;

endmodule

// File: tb/tb_uart_transceiver.sv
// Scoreboard bench for uart_transceiver: line-level TX decoder and RX strobe monitor.
module tb_uart_transceiver;

  localparam int unsigned CLK_FREQ = 1000000;
  localparam int unsigned BAUD     = 62500;
  localparam int unsigned CPB      = CLK_FREQ / BAUD;

  logic       clk      = 1'b0;
  logic       reset    = 1'b1;
  logic       transmit = 1'b0;
  logic [7:0] TxData   = 8'h00;
  logic       TxD, busy, valid_rx;
  logic [7:0] RxData;
  logic       RxD;
  logic       loop_sel = 1'b0;
  logic       rxd_drv  = 1'b1;

  assign RxD = loop_sel ? TxD : rxd_drv;

  uart_transceiver #(
    .CLK_FREQ(CLK_FREQ),
    .BAUD    (BAUD)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .transmit(transmit),
    .TxData  (TxData),
    .TxD     (TxD),
    .busy    (busy),
    .RxD     (RxD),
    .RxData  (RxData),
    .valid_rx(valid_rx)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         passed = 0;
  int         epoch  = 0;
  logic [7:0] exp_tx[$];
  logic [7:0] exp_rx[$];
  logic [7:0] last_rx = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Every strobe must match the oldest outstanding expected byte.
  always @(negedge clk) begin
    if (!reset && valid_rx) begin
      if (exp_rx.size() == 0) check("rx_unexpected_strobe", 32'(RxData), 32'hffff_ffff);
      else check("rx_byte", 32'(RxData), 32'(exp_rx.pop_front()));
    end
  end

  int busy_len = 0;
  always @(negedge clk) begin
    if (reset) busy_len = 0;
    else if (busy) busy_len++;
    else if (busy_len != 0) begin
      check("busy_len", busy_len, 10 * CPB);
      busy_len = 0;
    end
  end

  // Decode TxD as a line observer: find start edge, sample bit centres.
  initial begin : tx_mon
    logic       prev;
    logic       ok;
    logic [7:0] b;
    int         ep;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (!reset && prev && !TxD) begin
        ep = epoch;
        ok = 1'b1;
        repeat (CPB / 2) @(negedge clk);
        if (TxD !== 1'b0) ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          b[i] = TxD;
        end
        repeat (CPB) @(negedge clk);
        if (TxD !== 1'b1) ok = 1'b0;
        if (ep == epoch) begin
          check("tx_framing", 32'(ok), 32'd1);
          if (exp_tx.size() == 0) check("tx_unexpected_frame", 32'(b), 32'hffff_ffff);
          else check("tx_byte", 32'(b), 32'(exp_tx.pop_front()));
        end
      end
      prev = TxD;
    end
  end

  task automatic send_tx(input logic [7:0] b);
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 20 * CPB) begin
      @(negedge clk);
      n++;
    end
    transmit = 1'b1;
    TxData   = b;
    exp_tx.push_back(b);
    if (loop_sel) begin
      exp_rx.push_back(b);
      last_rx = b;
    end
    @(posedge clk);
    #1;
    transmit = 1'b0;
    TxData   = 8'($urandom);
    check("tx_start_busy", 32'(busy), 32'd1);
    check("tx_start_txd", 32'(TxD), 32'd0);
  endtask

  task automatic drive_rx(input logic [7:0] b, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    if (stop) begin
      exp_rx.push_back(b);
      last_rx = b;
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 10; i++) begin
      rxd_drv = f[i];
      repeat (CPB) @(posedge clk);
      #1;
    end
    rxd_drv = 1'b1;
  endtask

  task automatic drain(input int limit);
    int n;
    n = 0;
    while ((exp_tx.size() != 0 || exp_rx.size() != 0 || busy) && n < limit) begin
      @(negedge clk);
      n++;
    end
    check("drain_in_time", 32'(n < limit), 32'd1);
    repeat (2 * CPB) @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int gap;
    int n;
    #100;
    @(negedge clk);
    check("reset_txd", 32'(TxD), 32'd1);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_rxdata", 32'(RxData), 32'd0);
    check("reset_valid", 32'(valid_rx), 32'd0);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    // Single byte through an external TxD->RxD loop.
    loop_sel = 1'b1;
    send_tx(8'hA5);
    drain(40 * CPB);

    // Back-to-back with transmit held high.
    @(negedge clk);
    transmit = 1'b1;
    TxData   = 8'h00;
    exp_tx.push_back(8'h00);
    exp_rx.push_back(8'h00);
    @(posedge clk);
    #1;
    TxData = 8'hFF;
    exp_tx.push_back(8'hFF);
    exp_rx.push_back(8'hFF);
    last_rx = 8'hFF;
    n = 0;
    while (busy && n < 20 * CPB) begin
      @(negedge clk);
      n++;
    end
    gap = 0;
    while (!busy && gap < 4 * CPB) begin
      gap++;
      @(negedge clk);
    end
    check("b2b_gap", gap, 1);
    transmit = 1'b0;
    drain(40 * CPB);

    // transmit while busy is ignored.
    send_tx(8'h42);
    repeat (3 * CPB) @(negedge clk);
    transmit = 1'b1;
    TxData   = 8'h3C;
    @(posedge clk);
    #1;
    transmit = 1'b0;
    drain(40 * CPB);
    repeat (12 * CPB) @(negedge clk);
    check("ignored_no_busy", 32'(busy), 32'd0);

    // Short glitch on RxD.
    loop_sel = 1'b0;
    @(posedge clk);
    #1;
    rxd_drv = 1'b0;
    repeat (CPB / 4) @(posedge clk);
    #1;
    rxd_drv = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    check("glitch_rxdata_hold", 32'(RxData), 32'(last_rx));

    // Framing error, then a good frame.
    drive_rx(8'h5A, 1'b0);
    repeat (CPB) @(negedge clk);
    check("frame_err_hold", 32'(RxData), 32'(last_rx));
    drive_rx(8'h81, 1'b1);
    drain(40 * CPB);
    check("after_err_rxdata", 32'(RxData), 32'h81);

    // Randomised concurrent TX and RX traffic.
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          send_tx(8'($urandom));
          repeat ($urandom_range(0, 2 * CPB)) @(negedge clk);
        end
      end
      begin
        for (int i = 0; i < 6; i++) begin
          drive_rx(8'($urandom), $urandom_range(0, 3) != 0);
          repeat ($urandom_range(2, CPB)) @(posedge clk);
        end
      end
    join
    drain(60 * CPB);
    check("random_rxdata_hold", 32'(RxData), 32'(last_rx));

    // Reset with both directions mid-frame.
    @(posedge clk);
    #1;
    rxd_drv = 1'b0;
    send_tx(8'h5B);
    repeat (3 * CPB) @(negedge clk);
    epoch++;
    exp_tx.delete();
    exp_rx.delete();
    last_rx = 8'h00;
    reset   = 1'b1;
    rxd_drv = 1'b1;
    #1;
    check("midreset_txd", 32'(TxD), 32'd1);
    check("midreset_busy", 32'(busy), 32'd0);
    check("midreset_valid", 32'(valid_rx), 32'd0);
    check("midreset_rxdata", 32'(RxData), 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (12 * CPB) @(negedge clk);
    loop_sel = 1'b1;
    send_tx(8'hC3);
    drain(40 * CPB);
    check("post_reset_rxdata", 32'(RxData), 32'hC3);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
